// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, FSM encoding and default datapath width
package cpu_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } state_e;

endpackage

// File: rtl/shift_add_mul8.sv
// rtl/shift_add_mul8.sv - iterative shift-add multiplier, one partial product per step
module shift_add_mul8
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;

  // Accumulator value after the current step; exposed so the last step's add is included
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  assign product_o = acc_d;
  assign done_o    = step_i && (cnt_q == CW'(ITER - 1));

  // Load clears the accumulator and captures operands; each step consumes one multiplier bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (load_i) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      cnt_q    <= '0;
    end else if (step_i) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - multi-cycle ALU stage with save pulse, flags and busy
module alu_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MUL_ITER = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] alu_out,
  output logic             save,
  output logic             busy,
  output logic             carry,
  output logic             zero
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   alu_out_q, res_d;
  logic               carry_q, carry_d;
  logic               zero_q;
  logic               save_q;
  logic               done_vld;
  logic               mul_load, mul_step, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0]     sum_w, diff_w;

  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} - {1'b0, b};

  shift_add_mul8 #(
    .WIDTH (WIDTH),
    .ITER  (MUL_ITER)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .load_i    (mul_load),
    .step_i    (mul_step),
    .a_i       (a),
    .b_i       (b),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  // Next state, multiplier control and the result/flags to commit on completion
  always_comb begin
    state_d  = state_q;
    mul_load = 1'b0;
    mul_step = 1'b0;
    done_vld = 1'b0;
    res_d    = alu_out_q;
    carry_d  = carry_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (opcode == OP_MUL) begin
            mul_load = 1'b1;
            state_d  = ST_MUL_RUN;
          end else begin
            done_vld = 1'b1;
            case (opcode)
              OP_ADD:  begin res_d = sum_w[WIDTH-1:0];  carry_d = sum_w[WIDTH];  end
              OP_SUB:  begin res_d = diff_w[WIDTH-1:0]; carry_d = diff_w[WIDTH]; end
              OP_AND:  begin res_d = a & b;             carry_d = 1'b0;          end
              OP_OR:   begin res_d = a | b;             carry_d = 1'b0;          end
              OP_XOR:  begin res_d = a ^ b;             carry_d = 1'b0;          end
              OP_SHL:  begin res_d = {a[WIDTH-2:0], 1'b0}; carry_d = a[WIDTH-1]; end
              OP_SHR:  begin res_d = {1'b0, a[WIDTH-1:1]}; carry_d = a[0];       end
              default: begin res_d = '0;                carry_d = 1'b0;          end
            endcase
          end
        end
      end
      ST_MUL_RUN: begin
        mul_step = 1'b1;
        if (mul_done) begin
          done_vld = 1'b1;
          res_d    = mul_prod[WIDTH-1:0];
          carry_d  = |mul_prod[2*WIDTH-1:WIDTH];
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; result and flags only change on the edge that raises save
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      alu_out_q <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      save_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      save_q  <= done_vld;
      if (done_vld) begin
        alu_out_q <= res_d;
        carry_q   <= carry_d;
        zero_q    <= (res_d == '0);
      end
    end
  end

  assign alu_out = alu_out_q;
  assign save    = save_q;
  assign busy    = (state_q == ST_MUL_RUN);
  assign carry   = carry_q;
  assign zero    = zero_q;

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - self-checking bench for alu_unit against an arithmetic reference model
module tb_alu_unit;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] opcode;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [7:0] alu_out;
  logic       save;
  logic       busy;
  logic       carry;
  logic       zero;

  int checks   = 0;
  int failures = 0;

  alu_unit #(.WIDTH(8), .MUL_ITER(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .opcode  (opcode),
    .a       (op_a),
    .b       (op_b),
    .alu_out (alu_out),
    .save    (save),
    .busy    (busy),
    .carry   (carry),
    .zero    (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Returns {carry, result} computed with plain unsigned integer arithmetic
  function automatic logic [8:0] ref_alu(input logic [2:0] op, input int unsigned x, input int unsigned y);
    int unsigned r;
    bit c;
    case (op)
      3'd0: begin r = x + y;               c = (r > 255);  end
      3'd1: begin r = (x + 256 - y) % 256; c = (x < y);    end
      3'd2: begin r = x & y;               c = 1'b0;       end
      3'd3: begin r = x | y;               c = 1'b0;       end
      3'd4: begin r = x ^ y;               c = 1'b0;       end
      3'd5: begin r = (x * 2) % 256;       c = (x >= 128); end
      3'd6: begin r = x / 2;               c = (x % 2 == 1); end
      default: begin r = x * y;            c = (r > 255);  end
    endcase
    return {c, r[7:0]};
  endfunction

  task automatic run_op(input string name, input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    logic [8:0] exp;
    int lat;
    int exp_lat;
    bit got;
    exp     = ref_alu(op, x, y);
    exp_lat = (op == 3'd7) ? 9 : 1;
    @(negedge clk);
    start = 1'b1; opcode = op; op_a = x; op_b = y;
    lat = 0;
    got = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (lat == 1) begin
        checks++;
        if (busy !== (op == 3'd7)) begin
          failures++;
          $display("FAIL %s busy_after_start: got %b expected %b", name, busy, (op == 3'd7));
        end
      end
      if (save === 1'b1) got = 1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s save_timeout: no save within 20 cycles", name);
    end else begin
      if (lat != exp_lat) begin
        failures++;
        $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
      end
      checks++;
      if (alu_out !== exp[7:0]) begin
        failures++;
        $display("FAIL %s alu_out: got %h expected %h (a=%h b=%h)", name, alu_out, exp[7:0], x, y);
      end
      checks++;
      if (carry !== exp[8]) begin
        failures++;
        $display("FAIL %s carry: got %b expected %b (a=%h b=%h)", name, carry, exp[8], x, y);
      end
      checks++;
      if (zero !== (exp[7:0] == 8'h00)) begin
        failures++;
        $display("FAIL %s zero: got %b expected %b", name, zero, (exp[7:0] == 8'h00));
      end
    end
    @(negedge clk);
    checks++;
    if (save !== 1'b0 || alu_out !== exp[7:0] || carry !== exp[8]) begin
      failures++;
      $display("FAIL %s hold: save=%b alu_out=%h carry=%b expected save=0 alu_out=%h carry=%b",
               name, save, alu_out, carry, exp[7:0], exp[8]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (alu_out !== 8'h00 || save !== 1'b0 || busy !== 1'b0 || carry !== 1'b0 || zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: alu_out=%h save=%b busy=%b carry=%b zero=%b expected all 0",
               alu_out, save, busy, carry, zero);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op("add_wrap", 3'd0, 8'hFF, 8'h01);
    run_op("sub_borrow", 3'd1, 8'h05, 8'h07);
    run_op("shl", 3'd5, 8'h81, 8'h00);
    run_op("shr", 3'd6, 8'h81, 8'h00);
    run_op("mul_small", 3'd7, 8'h0C, 8'h0B);
    run_op("mul_ovf", 3'd7, 8'h20, 8'h10);
    run_op("mul_max", 3'd7, 8'hFF, 8'hFF);
    run_op("sub_equal", 3'd1, 8'h5A, 8'h5A);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op("random", 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
  endtask

  task automatic test_busy_ignore();
    logic [8:0] exp;
    int saves;
    int save_at;
    exp = ref_alu(3'd7, 8'h0D, 8'h07);
    saves = 0;
    save_at = 0;
    @(negedge clk);
    start = 1'b1; opcode = 3'd7; op_a = 8'h0D; op_b = 8'h07;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (save === 1'b1) begin
        saves++;
        save_at = c;
      end
      if (c == 2) begin
        start = 1'b1; opcode = 3'd0; op_a = 8'h01; op_b = 8'h01;
      end
    end
    checks++;
    if (saves != 1 || save_at != 9) begin
      failures++;
      $display("FAIL busy_ignore_saves: got %0d saves (last at %0d) expected 1 at 9", saves, save_at);
    end
    checks++;
    if (alu_out !== exp[7:0] || carry !== exp[8]) begin
      failures++;
      $display("FAIL busy_ignore_result: got %h/%b expected %h/%b", alu_out, carry, exp[7:0], exp[8]);
    end
  endtask

  task automatic test_reset_mid_mul();
    int saves;
    run_op("pre_reset_add", 3'd0, 8'h10, 8'h22);
    @(negedge clk);
    start = 1'b1; opcode = 3'd7; op_a = 8'h0F; op_b = 8'h0F;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (alu_out !== 8'h00 || save !== 1'b0 || busy !== 1'b0 || carry !== 1'b0 || zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_mul: alu_out=%h save=%b busy=%b carry=%b zero=%b expected all 0",
               alu_out, save, busy, carry, zero);
    end
    @(negedge clk);
    reset = 1'b0;
    saves = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (save === 1'b1) saves++;
    end
    checks++;
    if (saves != 0) begin
      failures++;
      $display("FAIL reset_mid_mul_no_save: got %0d saves expected 0", saves);
    end
    run_op("post_reset_add", 3'd0, 8'h02, 8'h03);
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops [3];
    logic [7:0] want [3];
    ops[0] = 3'd2; ops[1] = 3'd3; ops[2] = 3'd4;
    for (int i = 0; i < 3; i++) begin
      logic [8:0] r;
      r = ref_alu(ops[i], 8'hF0, 8'h3C);
      want[i] = r[7:0];
    end
    @(negedge clk);
    start = 1'b1; opcode = ops[0]; op_a = 8'hF0; op_b = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (save !== 1'b1 || alu_out !== want[i]) begin
        failures++;
        $display("FAIL back_to_back_%0d: save=%b alu_out=%h expected save=1 alu_out=%h", i, save, alu_out, want[i]);
      end
      if (i < 2) opcode = ops[i + 1];
      else start = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (save !== 1'b0 || alu_out !== want[2]) begin
      failures++;
      $display("FAIL back_to_back_end: save=%b alu_out=%h expected save=0 alu_out=%h", save, alu_out, want[2]);
    end
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    opcode = 3'd0;
    op_a   = 8'h00;
    op_b   = 8'h00;
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_mid_mul();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
